// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the seven-segment scan controller
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns indexed by nibble; 10..15 render as all segments off.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } phase_e;

endpackage

// File: rtl/seg_bcd_decode.sv
// rtl/seg_bcd_decode.sv - BCD nibble plus decimal point to active-low segment cathodes
module seg_bcd_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_i, SEG_LUT[nibble_i]};

endmodule

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - multiplexed 7-segment scanner with guard cycles and
// frame-atomic staging of display data
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_PRE = PW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [PW-1:0]                pcnt_q, pcnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  phase_e                       phase_q;
  logic [NUM_DIGITS-1:0][3:0]   stage_dig_q, stage_dig_d;
  logic [NUM_DIGITS-1:0]        stage_dp_q, stage_dp_d;
  logic [NUM_DIGITS-1:0][3:0]   shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
  logic                         pending_q, pending_d;
  logic                         frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]        an_q;
  logic [7:0]                   seg_q;

  logic                         tick;
  logic                         wrap;
  logic [NUM_DIGITS-1:0]        lz_zero;
  logic                         zero_acc;
  logic                         blank;
  logic [NUM_DIGITS-1:0]        an_sel;
  logic [7:0]                   dec_seg;

  seg_bcd_decode u_decode (
    .nibble_i (shadow_dig_q[idx_q]),
    .dp_i     (shadow_dp_q[idx_q]),
    .seg_o    (dec_seg)
  );

  always_comb begin
    tick = (pcnt_q == PCNT_MAX);
    wrap = tick && (idx_q == IDX_MAX);

    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end

    // A load coinciding with the commit still commits the previous staging value.
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    if (wrap && pending_q) begin
      shadow_dig_d = stage_dig_q;
      shadow_dp_d  = stage_dp_q;
    end

    stage_dig_d = stage_dig_q;
    stage_dp_d  = stage_dp_q;
    pending_d   = pending_q;
    if (wrap) begin
      pending_d = 1'b0;
    end
    if (load) begin
      stage_dig_d = digits_in;
      stage_dp_d  = dp_in;
      pending_d   = 1'b1;
    end

    // Registered one cycle early so the pulse coincides with the commit tick.
    frame_tick_d = (pcnt_q == PCNT_PRE) && (idx_q == IDX_MAX);
  end

  always_comb begin
    zero_acc = 1'b1;
    lz_zero  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc   = zero_acc && (shadow_dig_q[i] == 4'd0);
      lz_zero[i] = zero_acc;
    end
    blank  = !digit_en[idx_q] || (lz_blank && (idx_q != '0) && lz_zero[idx_q]);
    an_sel = ~(AN_ONE << idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      phase_q      <= GUARD;
      stage_dig_q  <= '0;
      stage_dp_q   <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      stage_dig_q  <= stage_dig_d;
      stage_dp_q   <= stage_dp_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      case (phase_q)
        GUARD: begin
          phase_q <= SHOW;
          an_q    <= blank ? '1 : an_sel;
          seg_q   <= blank ? SEG_BLANK : dec_seg;
        end
        SHOW: begin
          if (tick) begin
            phase_q <= GUARD;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
          end else begin
            an_q    <= blank ? '1 : an_sel;
            seg_q   <= blank ? SEG_BLANK : dec_seg;
          end
        end
        default: begin
          phase_q <= GUARD;
          an_q    <= '1;
          seg_q   <= SEG_BLANK;
        end
      endcase
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - directed self-checking bench for seg_scan_controller
module tb_seg_scan_controller;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        pending;
  logic        frame_tick;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the last edge that sampled reset high.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic goto(input int n);
    int k = 0;
    while (cyc < n) begin
      @(negedge clk);
      k++;
      if (k > 1000) begin
        n_checks++;
        n_errors++;
        $display("FAIL goto timeout waiting for cycle %0d", n);
        return;
      end
    end
  endtask

  // Walks one 16-cycle frame: guard slot then three lit cycles per digit.
  task automatic check_frame(input int f, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input logic [3:0] blank);
    logic [7:0] segs [4];
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    int slot;
    int pos;
    segs = '{s0, s1, s2, s3};
    for (int p = 0; p < 16; p++) begin
      goto(16 * f + p);
      slot    = p / 4;
      pos     = p % 4;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if (pos != 0 && !blank[slot]) begin
        exp_an[slot] = 1'b0;
        exp_seg      = segs[slot];
      end
      chk($sformatf("f%0d an p%0d", f, p), 32'(an), 32'(exp_an));
      chk($sformatf("f%0d seg p%0d", f, p), 32'(seg), 32'(exp_seg));
      chk($sformatf("f%0d frame_tick p%0d", f, p), 32'(frame_tick), 32'(p == 15));
    end
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset an", 32'(an), 32'hF);
    chk("reset seg", 32'(seg), 32'hFF);
    chk("reset pending", 32'(pending), 32'h0);
    chk("reset frame_tick", 32'(frame_tick), 32'h0);
    reset = 1'b0;

    check_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);

    goto(18);
    digits_in = 16'h1234; dp_in = 4'b0001; load = 1'b1;
    goto(19);
    load = 1'b0;
    chk("load pending set", 32'(pending), 32'h1);
    goto(31);
    chk("pending before commit", 32'(pending), 32'h1);
    chk("commit frame_tick", 32'(frame_tick), 32'h1);
    goto(32);
    chk("pending after commit", 32'(pending), 32'h0);
    check_frame(2, 8'h19, 8'hB0, 8'hA4, 8'hF9, 4'b0000);

    goto(50);
    digits_in = 16'h0007; dp_in = 4'b0000; lz_blank = 1'b1; load = 1'b1;
    goto(51);
    load = 1'b0;
    check_frame(4, 8'hF8, 8'hC0, 8'hC0, 8'hC0, 4'b1110);

    goto(82);
    digits_in = 16'h0000; load = 1'b1;
    goto(83);
    load = 1'b0;
    check_frame(6, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1110);

    goto(114);
    lz_blank = 1'b0; digits_in = 16'h1111; load = 1'b1;
    goto(115);
    load = 1'b0;
    goto(118);
    digits_in = 16'h2222; load = 1'b1;
    goto(119);
    load = 1'b0;
    goto(127);
    digits_in = 16'h3333; load = 1'b1;
    goto(128);
    load = 1'b0;
    chk("pending after load in commit cycle", 32'(pending), 32'h1);
    check_frame(8, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 4'b0000);
    goto(144);
    chk("pending after second commit", 32'(pending), 32'h0);
    check_frame(9, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 4'b0000);

    goto(162);
    digits_in = 16'h567A; dp_in = 4'b0001; digit_en = 4'b1011; load = 1'b1;
    goto(163);
    load = 1'b0;
    check_frame(11, 8'h7F, 8'hF8, 8'hFF, 8'h92, 4'b0100);

    goto(194);
    digits_in = 16'h9999; dp_in = 4'b0000; digit_en = 4'hF; load = 1'b1;
    goto(195);
    load = 1'b0;
    chk("pending before mid reset", 32'(pending), 32'h1);
    goto(200);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset an", 32'(an), 32'hF);
    chk("mid reset seg", 32'(seg), 32'hFF);
    chk("mid reset pending", 32'(pending), 32'h0);
    reset = 1'b0;
    check_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);
    goto(16);
    chk("staged data discarded", 32'(pending), 32'h0);
    check_frame(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
